// File: rtl/video_mode_scheduler.sv
// ---------------------------------------------------------------------------
// video_mode_scheduler
//   Chooses the test-pattern mode that the pattern generator shows. The mode
//   changes only at frame boundaries. It can rotate on a timer (auto_en),
//   counted in frames, or change on an explicit request.
//
// Ports
//   clk, rst_n           pixel clock, asynchronous active-low reset
//   next_pixel           the video output consumed a pixel this cycle
//   row_address          row of the current pixel
//   col_address          column of the current pixel
//   auto_en              enables automatic rotation every FRAMES_PER_MODE frames
//   req_valid/req_ready  mode request handshake
//   req_mode             requested mode
//   pattern_mode         mode currently driven to the pattern generator
//   mode_changed         one-cycle pulse in the first cycle a new mode is visible
//   req_error            one-cycle pulse after a request for an illegal mode
//   frame_count          frames completed, wraps at 16 bits
//
// Handshake: a request is taken in any cycle where req_valid && req_ready.
// req_ready depends only on state, never on req_valid. After a legal request
// is taken, req_ready stays low until the new mode has been applied.
// ---------------------------------------------------------------------------
module video_mode_scheduler #(
  parameter int ROW_ADDR_WIDTH  = 10,
  parameter int COL_ADDR_WIDTH  = 11,
  parameter int MAX_ROW         = 1024,
  parameter int MAX_COL         = 1280,
  parameter int MODE_WIDTH      = 2,
  parameter int NUM_MODES       = 4,
  parameter int FRAMES_PER_MODE = 60,
  parameter int RESET_MODE      = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      next_pixel,
  input  logic [ROW_ADDR_WIDTH-1:0] row_address,
  input  logic [COL_ADDR_WIDTH-1:0] col_address,
  input  logic                      auto_en,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [MODE_WIDTH-1:0]     req_mode,
  output logic [MODE_WIDTH-1:0]     pattern_mode,
  output logic                      mode_changed,
  output logic                      req_error,
  output logic [15:0]               frame_count
);

  localparam int DWELL_W = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PENDING = 2'd1,
    ST_APPLY   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [MODE_WIDTH-1:0] pattern_mode_q, pattern_mode_d;
  logic [MODE_WIDTH-1:0] stored_mode_q, stored_mode_d;
  logic [DWELL_W-1:0]    dwell_q, dwell_d;
  logic [15:0]           frame_count_q, frame_count_d;
  logic                  frame_end_q, frame_end_d;
  logic                  mode_changed_q, mode_changed_d;
  logic                  req_error_q, req_error_d;

  logic                  last_pixel;
  logic                  accept;
  logic                  req_legal;
  logic [MODE_WIDTH-1:0] next_mode;

  assign last_pixel = next_pixel &&
                      (row_address == ROW_ADDR_WIDTH'(MAX_ROW - 1)) &&
                      (col_address == COL_ADDR_WIDTH'(MAX_COL - 1));
  assign accept     = req_valid && (state_q == ST_RUN);
  assign req_legal  = int'(req_mode) < NUM_MODES;
  // Wrap to mode 0 when the current mode is out of range as well.
  assign next_mode  = (int'(pattern_mode_q) >= NUM_MODES - 1) ? '0
                                                              : pattern_mode_q + 1'b1;

  always_comb begin
    state_d        = state_q;
    pattern_mode_d = pattern_mode_q;
    stored_mode_d  = stored_mode_q;
    dwell_d        = dwell_q;
    mode_changed_d = 1'b0;
    req_error_d    = 1'b0;
    frame_end_d    = last_pixel;
    frame_count_d  = frame_count_q + {15'd0, frame_end_q};

    case (state_q)
      ST_RUN: begin
        if (accept) begin
          if (req_legal) begin
            stored_mode_d = req_mode;
            state_d       = ST_PENDING;
          end else begin
            req_error_d = 1'b1;
          end
        end
        // A request taken on this same frame_end waits for the next boundary.
        // It does not stop the auto rotation on this boundary.
        if (frame_end_q && auto_en) begin
          if (dwell_q == DWELL_W'(FRAMES_PER_MODE - 1)) begin
            pattern_mode_d = next_mode;
            dwell_d        = '0;
            mode_changed_d = 1'b1;
          end else begin
            dwell_d = dwell_q + 1'b1;
          end
        end
      end
      ST_PENDING: begin
        // The request wins over auto rotation on this boundary.
        if (frame_end_q) begin
          state_d = ST_APPLY;
          dwell_d = '0;
        end
      end
      ST_APPLY: begin
        state_d        = ST_RUN;
        pattern_mode_d = stored_mode_q;
        dwell_d        = '0;
        mode_changed_d = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      pattern_mode_q <= MODE_WIDTH'(RESET_MODE);
      stored_mode_q  <= '0;
      dwell_q        <= '0;
      frame_count_q  <= '0;
      frame_end_q    <= 1'b0;
      mode_changed_q <= 1'b0;
      req_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      pattern_mode_q <= pattern_mode_d;
      stored_mode_q  <= stored_mode_d;
      dwell_q        <= dwell_d;
      frame_count_q  <= frame_count_d;
      frame_end_q    <= frame_end_d;
      mode_changed_q <= mode_changed_d;
      req_error_q    <= req_error_d;
    end
  end

  assign req_ready    = (state_q == ST_RUN);
  assign pattern_mode = pattern_mode_q;
  assign mode_changed = mode_changed_q;
  assign req_error    = req_error_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_video_mode_scheduler.sv
// ---------------------------------------------------------------------------
// tb_video_mode_scheduler
//   Test bench for video_mode_scheduler. It uses a tiny 4x2 frame with a dwell
//   of 3 frames. The reference model works on frame boundaries: for each
//   boundary it plans when the mode, the frame count, the error pulse and the
//   ready signal will change, and stores those planned events by cycle number.
//   A second instance with NUM_MODES=3 tests requests for illegal modes.
// ---------------------------------------------------------------------------
module tb_video_mode_scheduler;

  localparam int MAX_ROW = 2;
  localparam int MAX_COL = 4;
  localparam int FPM     = 3;
  localparam int NMODES  = 4;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        next_pixel = 1'b0;
  logic        auto_en = 1'b0;
  logic        req_valid = 1'b0;
  logic [1:0]  req_mode = 2'd0;
  logic [9:0]  row_address = '0;
  logic [10:0] col_address = '0;

  logic        req_ready, mode_changed, req_error;
  logic [1:0]  pattern_mode;
  logic [15:0] frame_count;
  logic        req_ready_3, mode_changed_3, req_error_3;
  logic [1:0]  pattern_mode_3;
  logic [15:0] frame_count_3;

  always #5 clk = ~clk;

  video_mode_scheduler #(
    .MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL), .NUM_MODES(NMODES), .FRAMES_PER_MODE(FPM)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .next_pixel(next_pixel),
    .row_address(row_address), .col_address(col_address), .auto_en(auto_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .pattern_mode(pattern_mode), .mode_changed(mode_changed),
    .req_error(req_error), .frame_count(frame_count)
  );

  video_mode_scheduler #(
    .MAX_ROW(MAX_ROW), .MAX_COL(MAX_COL), .NUM_MODES(3), .FRAMES_PER_MODE(FPM)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .next_pixel(next_pixel),
    .row_address(row_address), .col_address(col_address), .auto_en(auto_en),
    .req_valid(req_valid), .req_ready(req_ready_3), .req_mode(req_mode),
    .pattern_mode(pattern_mode_3), .mode_changed(mode_changed_3),
    .req_error(req_error_3), .frame_count(frame_count_3)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model ----------------
  int  cyc, m_mode, m_fc, m_dwell, m_pend_mode, m_acc_cyc, busy_from, busy_until;
  bit  m_pend, fe_now;
  int  mode_at[int];
  bit  err_at[int];
  bit  fc_at[int];
  logic [1:0]  exp_mode;
  logic [15:0] exp_fc;
  logic        exp_mc, exp_err, exp_ready;
  int  pix_row, pix_col;

  task automatic model_reset();
    cyc = 0; m_mode = 1; m_fc = 0; m_dwell = 0; m_pend = 0;
    m_pend_mode = 0; m_acc_cyc = 0; busy_from = 0; busy_until = 0; fe_now = 0;
    mode_at.delete(); err_at.delete(); fc_at.delete();
    pix_row = 0; pix_col = 0;
  endtask

  // Computes the expected outputs for the current cycle. Then it uses this
  // cycle's inputs to plan events for later cycles.
  task automatic model_step(input bit ae, input bit rv, input int rm, input bit last);
    exp_mc = 1'b0;
    if (mode_at.exists(cyc)) begin
      m_mode = mode_at[cyc];
      exp_mc = 1'b1;
    end
    if (fc_at.exists(cyc)) m_fc = (m_fc + 1) % 65536;
    exp_err   = err_at.exists(cyc);
    exp_ready = !(cyc >= busy_from && cyc < busy_until);
    exp_mode  = 2'(m_mode);
    exp_fc    = 16'(m_fc);
    if (fe_now) begin
      fc_at[cyc + 1] = 1'b1;
      if (m_pend && m_acc_cyc < cyc) begin
        mode_at[cyc + 2] = m_pend_mode;
        m_dwell = 0; m_pend = 0; busy_until = cyc + 2;
      end else if (ae) begin
        if (m_dwell == FPM - 1) begin
          mode_at[cyc + 1] = (m_mode + 1) % NMODES;
          m_dwell = 0;
        end else begin
          m_dwell++;
        end
      end
    end
    if (rv && exp_ready) begin
      if (rm < NMODES) begin
        m_pend = 1; m_pend_mode = rm; m_acc_cyc = cyc;
        busy_from = cyc + 1; busy_until = 1 << 30;
      end else begin
        err_at[cyc + 1] = 1'b1;
      end
    end
    fe_now = last;
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    next_pixel = 1'b0; req_valid = 1'b0; auto_en = 1'b0; req_mode = 2'd0;
    row_address = '0; col_address = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drives one cycle of input and returns at the negedge so the caller can sample outputs.
  task automatic tick(input bit np, input bit ae, input bit rv, input logic [1:0] rm);
    bit last;
    @(posedge clk); #1;
    next_pixel = np; auto_en = ae; req_valid = rv; req_mode = rm;
    row_address = 10'(pix_row); col_address = 11'(pix_col);
    last = np && pix_row == MAX_ROW - 1 && pix_col == MAX_COL - 1;
    @(negedge clk);
    model_step(ae, rv, int'(rm), last);
    if (np) begin
      pix_col++;
      if (pix_col == MAX_COL) begin
        pix_col = 0;
        pix_row = (pix_row + 1) % MAX_ROW;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    next_pixel = 1'b0; req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (pattern_mode !== 2'd1 || frame_count !== 16'd0 || mode_changed !== 1'b0 || req_error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: mode=%0d fc=%0d mc=%b err=%b, required mode=1 fc=0 mc=0 err=0",
               pattern_mode, frame_count, mode_changed, req_error);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    tick(1'b1, 1'b0, 1'b0, 2'd0);
    n_tests++;
    if (req_ready !== 1'b1 || pattern_mode !== 2'd1 || frame_count !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b mode=%0d fc=%0d, required ready=1 mode=1 fc=0",
               req_ready, pattern_mode, frame_count);
    end
  endtask

  task automatic test_static();
    int mc_count = 0;
    do_reset();
    for (int c = 0; c < 42; c++) begin
      tick(1'b1, 1'b0, 1'b0, 2'd0);
      if (mode_changed === 1'b1) mc_count++;
      n_tests++;
      if (pattern_mode !== 2'd1 || frame_count !== exp_fc) begin
        n_fail++;
        $display("FAIL static c%0d: mode=%0d fc=%0d, required mode=1 fc=%0d", c, pattern_mode, frame_count, exp_fc);
      end
    end
    n_tests++;
    if (frame_count !== 16'd5 || mc_count != 0) begin
      n_fail++;
      $display("FAIL static_end: fc=%0d pulses=%0d, required fc=5 pulses=0", frame_count, mc_count);
    end
  endtask

  task automatic test_auto();
    int mc_count = 0;
    do_reset();
    for (int c = 0; c < 60; c++) begin
      tick(1'b1, 1'b1, 1'b0, 2'd0);
      if (mode_changed === 1'b1) mc_count++;
      n_tests++;
      if (pattern_mode !== exp_mode || mode_changed !== exp_mc || mode_changed !== ((c == 25) || (c == 49))) begin
        n_fail++;
        $display("FAIL auto c%0d: mode=%0d mc=%b, required mode=%0d mc=%b", c, pattern_mode, mode_changed, exp_mode, exp_mc);
      end
    end
    n_tests++;
    if (pattern_mode !== 2'd3 || frame_count !== 16'd7 || mc_count != 2) begin
      n_fail++;
      $display("FAIL auto_end: mode=%0d fc=%0d pulses=%0d, required 3 7 2", pattern_mode, frame_count, mc_count);
    end
  endtask

  task automatic test_request();
    int mc_count = 0;
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tick(1'b1, 1'b0, c == 3, 2'd3);
      if (mode_changed === 1'b1) mc_count++;
      n_tests++;
      if (req_ready !== exp_ready || req_ready !== !(c >= 4 && c <= 9) ||
          pattern_mode !== exp_mode || pattern_mode !== ((c >= 10) ? 2'd3 : 2'd1)) begin
        n_fail++;
        $display("FAIL request c%0d: ready=%b mode=%0d, required ready=%b mode=%0d", c, req_ready, pattern_mode, exp_ready, exp_mode);
      end
    end
    n_tests++;
    if (mc_count != 1) begin
      n_fail++;
      $display("FAIL request_pulses: got %0d, required 1", mc_count);
    end
  endtask

  task automatic test_error();
    do_reset();
    for (int c = 0; c < 20; c++) begin
      tick(1'b1, 1'b0, c == 2, 2'd3);
      n_tests++;
      if (req_error_3 !== (c == 3) || req_ready_3 !== 1'b1 || pattern_mode_3 !== 2'd1 || mode_changed_3 !== 1'b0) begin
        n_fail++;
        $display("FAIL error c%0d: err=%b ready=%b mode=%0d mc=%b, required err=%b ready=1 mode=1 mc=0",
                 c, req_error_3, req_ready_3, pattern_mode_3, mode_changed_3, c == 3);
      end
    end
  endtask

  task automatic test_back_to_back();
    int mc_count = 0;
    do_reset();
    for (int c = 0; c < 46; c++) begin
      tick(1'b1, 1'b1, c == 24, 2'd0);
      if (mode_changed === 1'b1) mc_count++;
      n_tests++;
      if (pattern_mode !== exp_mode || mode_changed !== exp_mc || req_ready !== exp_ready ||
          (c == 25 && pattern_mode !== 2'd2) || (c == 34 && pattern_mode !== 2'd0)) begin
        n_fail++;
        $display("FAIL b2b c%0d: mode=%0d mc=%b ready=%b, required mode=%0d mc=%b ready=%b",
                 c, pattern_mode, mode_changed, req_ready, exp_mode, exp_mc, exp_ready);
      end
    end
    n_tests++;
    if (mc_count != 2) begin
      n_fail++;
      $display("FAIL b2b_pulses: got %0d, required 2", mc_count);
    end
  endtask

  task automatic test_reset_pending();
    int mc_count = 0;
    do_reset();
    for (int c = 0; c < 12; c++) tick(1'b1, 1'b0, c == 10, 2'd2);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (pattern_mode !== 2'd1 || frame_count !== 16'd0 || mode_changed !== 1'b0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pending: mode=%0d fc=%0d mc=%b ready=%b, required 1 0 0 1",
               pattern_mode, frame_count, mode_changed, req_ready);
    end
    do_reset();
    for (int c = 0; c < 30; c++) begin
      tick(1'b1, 1'b0, 1'b0, 2'd0);
      if (mode_changed === 1'b1) mc_count++;
    end
    n_tests++;
    if (mc_count != 0 || pattern_mode !== 2'd1) begin
      n_fail++;
      $display("FAIL reset_pending_after: pulses=%0d mode=%0d, required 0 1", mc_count, pattern_mode);
    end
  endtask

  task automatic test_random();
    bit ae = 1'b0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 15) == 0) ae = ~ae;
      tick($urandom_range(0, 9) != 0, ae, $urandom_range(0, 5) == 0, 2'($urandom_range(0, 3)));
      n_tests++;
      if (pattern_mode !== exp_mode || mode_changed !== exp_mc || req_ready !== exp_ready ||
          req_error !== exp_err || frame_count !== exp_fc) begin
        n_fail++;
        $display("FAIL random c%0d: mode=%0d mc=%b ready=%b err=%b fc=%0d, required %0d %b %b %b %0d",
                 c, pattern_mode, mode_changed, req_ready, req_error, frame_count,
                 exp_mode, exp_mc, exp_ready, exp_err, exp_fc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_static();
    test_auto();
    test_request();
    test_error();
    test_back_to_back();
    test_reset_pending();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/video_mode_scheduler.md
VIDEO_MODE_SCHEDULER -- requirements
Module: video_mode_scheduler

Interface
REQ-001 SHALL have parameters (name, default, meaning): ROW_ADDR_WIDTH, 10, row address width; COL_ADDR_WIDTH, 11, column address width; MAX_ROW, 1024, active rows; MAX_COL, 1280, active columns; MODE_WIDTH, 2, pattern mode width; NUM_MODES, 4, number of legal modes; FRAMES_PER_MODE, 60, auto dwell in frames; RESET_MODE, 1, mode after reset.
REQ-002 SHALL have port clk, input, 1, pixel-domain clock (clk_100M at top); one clock only.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port next_pixel, input, 1, pixel consumed by video output this cycle.
REQ-005 SHALL have port row_address, input, ROW_ADDR_WIDTH, current pixel row.
REQ-006 SHALL have port col_address, input, COL_ADDR_WIDTH, current pixel column.
REQ-007 SHALL have port auto_en, input, 1, enable automatic mode rotation.
REQ-008 SHALL have ports req_valid (input, 1), req_ready (output, 1) and req_mode (input, MODE_WIDTH): mode change request handshake.
REQ-009 SHALL have port pattern_mode, output, MODE_WIDTH, mode driven to pattern generator.
REQ-010 SHALL have ports mode_changed (output, 1, one-cycle pulse), req_error (output, 1, one-cycle pulse) and frame_count (output, 16, frames completed).

Function
REQ-011 SHALL detect frame end when next_pixel=1, row_address=MAX_ROW-1 and col_address=MAX_COL-1 in cycle T; internal frame_end registered high in T+1 only.
REQ-012 SHALL increment frame_count on each frame_end, wrapping 0xFFFF->0x0000.
REQ-013 SHALL implement states RUN, PENDING, APPLY; reset state RUN.
REQ-014 SHALL drive req_ready=1 only in RUN; a request is accepted on req_valid&req_ready.
REQ-015 On accept with req_mode<NUM_MODES SHALL store req_mode and go RUN->PENDING.
REQ-016 On accept with req_mode>=NUM_MODES SHALL pulse req_error the next cycle, remain RUN, leave pattern_mode unchanged.
REQ-017 PENDING SHALL wait for frame_end, then go APPLY; APPLY SHALL last one cycle, then RUN.
REQ-018 Leaving APPLY SHALL load pattern_mode with stored mode and clear the dwell counter; new mode visible in T+3 relative to last-pixel cycle T.
REQ-019 Dwell counter SHALL count frame_end events in RUN while auto_en=1; held (not cleared) while auto_en=0.
REQ-020 In RUN with auto_en=1, frame_end with dwell=FRAMES_PER_MODE-1 SHALL advance pattern_mode to (pattern_mode+1) mod NUM_MODES and clear dwell; new mode visible T+2.
REQ-021 mode_changed SHALL be high exactly in the first cycle a new pattern_mode is visible, including when the new value equals the old one.
REQ-022 A request accepted in the same cycle as frame_end in RUN SHALL NOT use that frame_end; auto advance on that frame_end still occurs; request applies at the next frame_end.
REQ-023 In PENDING, frame_end SHALL never auto-advance; the request wins and dwell is cleared.
REQ-024 pattern_mode SHALL change only as in REQ-018/REQ-020, hence only at frame boundaries.

Reset
REQ-025 rst_n low SHALL asynchronously set state RUN, pattern_mode=RESET_MODE, frame_count=0, dwell=0, stored mode=0, frame_end=0, mode_changed=0, req_error=0; req_ready=1 after release.
REQ-026 Reset mid-PENDING SHALL discard the stored request; no mode_changed pulse follows.
REQ-027 Outputs SHALL be registered except req_ready (decoded from state).

Verification (MAX_COL=4, MAX_ROW=2, FRAMES_PER_MODE=3, NUM_MODES=4, next_pixel=1 always)
REQ-028 Reset release, auto_en=0, 5 frames -> pattern_mode=1 constant, frame_count=5, no mode_changed.
REQ-029 auto_en=1, 7 frames -> pattern_mode 1->2 after frame 3, 2->3 after frame 6; mode_changed twice, each at T+2.
REQ-030 auto_en=0, req_mode=3 mid-frame -> req_ready drops next cycle, pattern_mode=3 at T+3 of frame end, one mode_changed, req_ready back high.
REQ-031 req_mode=3 with NUM_MODES=3 -> req_error one pulse, state stays RUN, pattern_mode unchanged.
REQ-032 auto_en=1, request accepted on frame_end cycle completing dwell -> auto advance at that boundary, request applied at following boundary; exactly two mode_changed pulses.
REQ-033 rst_n asserted while PENDING -> pattern_mode=1, frame_count=0, no later mode_changed without new request.
